// File: rtl/led_pulse_stretcher.sv
// Stretches 1-cycle event strobes into LED blinks with a guaranteed on-time and off-gap.
// Events arriving while a blink is in progress are queued in a saturating counter and replayed.
module led_pulse_stretcher #(
  parameter int ON_CYCLES  = 4194303,
  parameter int OFF_CYCLES = 4194303,
  parameter int PEND_BITS  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 trigger,
  output logic                 led,
  output logic                 busy,
  output logic [PEND_BITS-1:0] pending,
  output logic                 overflow
);

  localparam int MAX_C = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW    = $clog2(MAX_C + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [TW-1:0]        ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0]        OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [TW-1:0]        T_ONE    = TW'(1);
  localparam logic [PEND_BITS-1:0] PEND_ONE = PEND_BITS'(1);
  localparam logic [PEND_BITS-1:0] PEND_MAX = '1;

  logic [1:0]           r_state;
  logic [TW-1:0]        r_timer;
  logic [PEND_BITS-1:0] r_pending;
  logic                 r_overflow;
  logic                 r_led;
  logic                 r_busy;

  logic [1:0]           w_state_nxt;
  logic [TW-1:0]        w_timer_nxt;
  logic [PEND_BITS-1:0] w_pend_nxt;
  logic                 w_ovf_nxt;
  logic                 w_enq;

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_pend_nxt  = r_pending;
    w_ovf_nxt   = r_overflow;
    w_enq       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (trigger) begin
          w_state_nxt = S_ON;
          w_timer_nxt = ON_LOAD;
        end
      end
      S_ON: begin
        w_enq = trigger;
        if (r_timer == '0) begin
          w_state_nxt = S_GAP;
          w_timer_nxt = OFF_LOAD;
        end else begin
          w_timer_nxt = r_timer - T_ONE;
        end
      end
      S_GAP: begin
        if (r_timer != '0) begin
          w_enq       = trigger;
          w_timer_nxt = r_timer - T_ONE;
        end else if (r_pending != '0) begin
          // Dequeue one event; a trigger this same cycle replaces it, so no saturation check.
          w_state_nxt = S_ON;
          w_timer_nxt = ON_LOAD;
          if (!trigger) w_pend_nxt = r_pending - PEND_ONE;
        end else if (trigger) begin
          w_state_nxt = S_ON;
          w_timer_nxt = ON_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = '0;
      end
    endcase
    if (w_enq) begin
      if (r_pending == PEND_MAX) w_ovf_nxt = 1'b1;
      else                       w_pend_nxt = r_pending + PEND_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_pending  <= '0;
      r_overflow <= 1'b0;
      r_led      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_pending  <= w_pend_nxt;
      r_overflow <= w_ovf_nxt;
      r_led      <= (w_state_nxt == S_ON);
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  assign led      = r_led;
  assign busy     = r_busy;
  assign pending  = r_pending;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Directed bench for led_pulse_stretcher (ON=3, OFF=2, PEND_BITS=2); expected per-cycle
// outputs are queued as each step is driven and compared after the clock edge.
module tb_led_pulse_stretcher;

  typedef struct packed {
    logic       led;
    logic       busy;
    logic [1:0] pend;
    logic       ovf;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       trigger = 1'b0;
  logic       led;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int   n_cmp = 0;
  int   n_err = 0;
  obs_t exp_q[$];

  led_pulse_stretcher #(
    .ON_CYCLES (3),
    .OFF_CYCLES(2),
    .PEND_BITS (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .trigger (trigger),
    .led     (led),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic cyc(input string tag, input int idx, input logic trg, input logic rst, input obs_t e);
    obs_t o;
    obs_t x;
    trigger = trg;
    reset   = rst;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    o.led  = led;
    o.busy = busy;
    o.pend = pending;
    o.ovf  = overflow;
    x = exp_q.pop_front();
    n_cmp++;
    assert (o === x) else begin
      n_err++;
      $error("FAIL %s[%0d]: observed led/busy/pend/ovf=%b required %b", tag, idx, o, x);
    end
  endtask

  // One character per clock cycle: trigger driven before the edge, outputs expected after it.
  task automatic run(input string tag, input string trg_s, input string led_s,
                     input string busy_s, input string pend_s, input string ovf_s);
    obs_t e;
    for (int i = 0; i < trg_s.len(); i++) begin
      e.led  = (led_s[i] == "1");
      e.busy = (busy_s[i] == "1");
      e.pend = 2'(pend_s[i] - 8'h30);
      e.ovf  = (ovf_s[i] == "1");
      cyc(tag, i, (trg_s[i] == "1"), 1'b0, e);
    end
  endtask

  task automatic do_reset(input string tag, input logic trg);
    cyc(tag, 0, trg, 1'b1, '0);
  endtask

  initial begin
    do_reset("reset0", 1'b0);
    do_reset("reset1", 1'b0);
    run("idle", "000", "000", "000", "000", "000");

    run("single",
        "1000000",
        "1110000",
        "1111100",
        "0000000",
        "0000000");

    run("burst3",
        "11100000000000000",
        "11100111001110000",
        "11111111111111100",
        "01222111110000000",
        "00000000000000000");

    run("sat",
        "1111100000000000000000",
        "1110011100111001110000",
        "1111111111111111111100",
        "0123322222111110000000",
        "0000111111111111111111");

    do_reset("rst_after_sat", 1'b0);
    run("ovf_cleared", "00", "00", "00", "00", "00");

    run("gap_edge",
        "100001000000",
        "111001110000",
        "111111111100",
        "000000000000",
        "000000000000");

    run("pre_rst",
        "111110",
        "111001",
        "111111",
        "012332",
        "000011");
    do_reset("rst_mid_on", 1'b0);
    run("post_rst",
        "0000000000",
        "0000000000",
        "0000000000",
        "0000000000",
        "0000000000");

    do_reset("trig_with_rst", 1'b1);
    run("after_trig_rst",
        "000000",
        "000000",
        "000000",
        "000000",
        "000000");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
